// File: rtl/trig_record_reader.sv
// Trigger record FIFO (8 deep) with a word-serial readout FSM.
// Optional macro TRIG_RECORD_SEQNUM_EN adds a third word carrying a record sequence number.
module trig_record_reader (
    input  logic        clk_adc,
    input  logic        reset,
    input  logic        clear,
    input  logic        rec_valid,
    input  logic [7:0]  rec_bits,
    input  logic [55:0] rec_time,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  fifo_level,
    output logic [15:0] overflow_count
);
    localparam int unsigned Depth = 8;

`ifdef TRIG_RECORD_SEQNUM_EN
    typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;
    localparam state_e LastSt = StW2;
`else
    typedef enum logic [1:0] {StIdle, StW0, StW1} state_e;
    localparam state_e LastSt = StW1;
`endif

    logic [63:0] r_mem [Depth];
    logic [2:0]  r_wptr, r_rptr;
    logic [3:0]  r_level;
    logic [15:0] r_ovf;
    state_e      r_state, w_state_next;
    logic [31:0] r_data, w_data_next;
    logic        r_valid, w_valid_next;
    logic        r_last, w_last_next;

    logic [63:0] w_head;
    logic        w_xfer, w_pop, w_rec_ok, w_full, w_wr, w_drop;
    logic [3:0]  w_level_next;

    assign w_head   = r_mem[r_rptr];
    assign w_xfer   = r_valid && out_ready;
    assign w_pop    = w_xfer && (r_state == LastSt) && !clear;
    assign w_rec_ok = rec_valid && (rec_bits != 8'd0) && !clear;
    assign w_full   = (r_level == 4'd8);
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign w_wr     = w_rec_ok && (!w_full || w_pop);
    assign w_drop   = w_rec_ok && w_full && !w_pop;
    assign w_level_next = r_level + 4'(w_wr) - 4'(w_pop);

`ifdef TRIG_RECORD_SEQNUM_EN
    logic [15:0] r_seq;

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            r_seq <= 16'd0;
        end else if (clear) begin
            r_seq <= 16'd0;
        end else if (w_pop) begin
            r_seq <= r_seq + 16'd1;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_valid_next = r_valid;
        w_last_next  = r_last;
        unique case (r_state)
            StIdle: begin
                if (r_level != 4'd0) w_state_next = StW0;
            end
            // W0 spends its first cycle loading the head word into the output register.
            StW0: begin
                if (!r_valid) begin
                    w_data_next  = w_head[63:32];
                    w_valid_next = 1'b1;
                    w_last_next  = 1'b0;
                end else if (out_ready) begin
                    w_data_next  = w_head[31:0];
                    w_last_next  = (LastSt == StW1);
                    w_state_next = StW1;
                end
            end
`ifdef TRIG_RECORD_SEQNUM_EN
            StW1: begin
                if (out_ready) begin
                    w_data_next  = {8'hA5, 8'h00, r_seq};
                    w_last_next  = 1'b1;
                    w_state_next = StW2;
                end
            end
            StW2: begin
`else
            StW1: begin
`endif
                if (out_ready) begin
                    w_valid_next = 1'b0;
                    w_last_next  = 1'b0;
                    w_state_next = (w_level_next != 4'd0) ? StW0 : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_adc) begin
        if (w_wr) r_mem[r_wptr] <= {rec_bits, rec_time};
    end

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_data  <= 32'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_level <= 4'd0;
            r_wptr  <= 3'd0;
            r_rptr  <= 3'd0;
            r_ovf   <= 16'd0;
        end else if (clear) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_level <= 4'd0;
            r_wptr  <= 3'd0;
            r_rptr  <= 3'd0;
            r_ovf   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_last  <= w_last_next;
            r_level <= w_level_next;
            r_wptr  <= r_wptr + 3'(w_wr);
            r_rptr  <= r_rptr + 3'(w_pop);
            if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
        end
    end

    assign out_data       = r_data;
    assign out_valid      = r_valid;
    assign out_last       = r_last;
    assign fifo_level     = r_level;
    assign overflow_count = r_ovf;

endmodule

// File: tb/tb_trig_record_reader.sv
// Randomised plus directed bench for trig_record_reader against a queue-based record model.
module tb_trig_record_reader;
`ifdef TRIG_RECORD_SEQNUM_EN
    localparam int NW = 3;
`else
    localparam int NW = 2;
`endif

    logic        clk_adc = 1'b0;
    logic        reset, clear, rec_valid, out_ready;
    logic [7:0]  rec_bits;
    logic [55:0] rec_time;
    logic [31:0] out_data;
    logic        out_valid, out_last;
    logic [3:0]  fifo_level;
    logic [15:0] overflow_count;

    trig_record_reader dut (
        .clk_adc        (clk_adc),
        .reset          (reset),
        .clear          (clear),
        .rec_valid      (rec_valid),
        .rec_bits       (rec_bits),
        .rec_time       (rec_time),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #4 clk_adc = ~clk_adc;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: queue of accepted records, word index into the head, drop count, sequence.
    logic [63:0] m_q[$];
    int          m_idx = 0;
    logic [15:0] m_ovf = 16'd0;
    logic [15:0] m_seq = 16'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_word(input logic [63:0] r, input int idx,
                                             input logic [15:0] s);
        if (idx == 0) return r[63:32];
        else if (idx == 1) return r[31:0];
        else return {8'hA5, 8'h00, s};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idx = 0;
        m_ovf = 16'd0;
        m_seq = 16'd0;
    endtask

    // Called at posedge+1: update the model for the coming edge, advance, then compare.
    task automatic cyc();
        logic        xfer, pop, hold;
        logic [31:0] hd;
        xfer = out_valid && out_ready;
        hold = out_valid && !out_ready && !clear;
        hd   = out_data;
        pop  = 1'b0;
        if (clear) begin
            model_reset();
        end else begin
            if (xfer) begin
                chk("xfer_nonempty", 64'(m_q.size() == 0), 64'd0);
                if (m_q.size() != 0) begin
                    chk("word", 64'(out_data), 64'(exp_word(m_q[0], m_idx, m_seq)));
                    chk("last", 64'(out_last), 64'(m_idx == NW - 1));
                    if (m_idx == NW - 1) pop = 1'b1;
                    else m_idx++;
                end
            end
            if (rec_valid && rec_bits != 8'd0) begin
                if (m_q.size() >= 8 && !pop) begin
                    if (m_ovf != 16'hFFFF) m_ovf++;
                end else begin
                    m_q.push_back({rec_bits, rec_time});
                end
            end
            if (pop) begin
                void'(m_q.pop_front());
                m_idx = 0;
                m_seq++;
            end
        end
        @(posedge clk_adc);
        #1;
        chk("level", 64'(fifo_level), 64'(m_q.size()));
        chk("ovf", 64'(overflow_count), 64'(m_ovf));
        if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(hd));
        end
        if (out_valid) chk("valid_has_rec", 64'(m_q.size() != 0), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic push(input logic [7:0] b, input logic [55:0] t);
        rec_valid = 1'b1;
        rec_bits  = b;
        rec_time  = t;
        cyc();
        rec_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((fifo_level != 4'd0 || out_valid) && n < 100) begin
            cyc();
            n++;
        end
        chk("drained", 64'(fifo_level != 4'd0 || out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] d0;
        logic [63:0] rt;
        int cnt;
        reset = 1'b1; clear = 1'b0; rec_valid = 1'b0; rec_bits = 8'd0;
        rec_time = 56'd0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_adc);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf", 64'(overflow_count), 64'd0);
        reset = 1'b0;

        // Single record latency and word format.
        out_ready = 1'b1;
        push(8'h05, 56'h00_1234_5678_9ABC);
        chk("lat_e0", 64'(out_valid), 64'd0);
        cyc();
        chk("lat_e1", 64'(out_valid), 64'd0);
        cyc();
        chk("lat_e2_valid", 64'(out_valid), 64'd1);
        chk("lat_e2_w0", 64'(out_data), 64'h0500_1234);
        cyc();
        chk("w1_data", 64'(out_data), 64'h5678_9ABC);
        chk("w1_last", 64'(out_last), 64'(NW == 2));
        repeat (NW - 1) cyc();
        chk("single_done", 64'(out_valid), 64'd0);
        chk("single_level", 64'(fifo_level), 64'd0);

        // Backpressure during W0.
        out_ready = 1'b0;
        push(8'h3C, 56'hAB_CDEF_0123_4567);
        wait_valid("bp_wait");
        d0 = out_data;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'(d0));
        end
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) cnt++;
            cyc();
        end
        chk("bp_xfers", 64'(cnt), 64'(NW));

        // Full FIFO with a last-word pop on the same edge as a write.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i + 16), 56'(i * 1000 + 7));
        wait_valid("fp_wait");
        out_ready = 1'b1;
        cnt = 0;
        while (!(out_valid && out_last) && cnt < 10) begin
            cyc();
            cnt++;
        end
        chk("fp_reach_last", 64'(out_last), 64'd1);
        push(8'hEE, 56'h11_2222_3333_4444);
        chk("fp_level", 64'(fifo_level), 64'd8);
        chk("fp_ovf", 64'(overflow_count), 64'd0);
        drain();

        // Overflow: 10 records into a stalled reader.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'(i + 1), 56'(56'h10_0000_0000 * (i + 1) + i));
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_count", 64'(overflow_count), 64'd2);
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid && out_ready && out_last) cnt++;
            cyc();
        end
        chk("ovf_drained", 64'(cnt), 64'd8);

        // Zero mask is discarded silently.
        push(8'h00, 56'h77_7777_7777_7777);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("zero_valid", 64'(out_valid), 64'd0);
        end
        chk("zero_level", 64'(fifo_level), 64'd0);
        chk("zero_ovf_kept", 64'(overflow_count), 64'd2);

        // Clear while in W1 with 3 records queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(i + 40), 56'(i + 99));
        wait_valid("clr_wait");
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("clr_in_w1", 64'(out_valid), 64'd1);
        clear = 1'b1;
        out_ready = 1'b1;
        push(8'h81, 56'h1);
        clear = 1'b0;
        out_ready = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_last", 64'(out_last), 64'd0);
        chk("clr_level", 64'(fifo_level), 64'd0);
        chk("clr_ovf", 64'(overflow_count), 64'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rt        = {$urandom, $urandom};
            rec_valid = ($urandom_range(0, 99) < 40);
            rec_bits  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            rec_time  = rt[55:0];
            out_ready = ($urandom_range(0, 99) < 55);
            clear     = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rec_valid = 1'b0;
        clear = 1'b0;
        drain();

        // Reset mid-record abandons it; first write after release is accepted.
        out_ready = 1'b0;
        push(8'h99, 56'h55_4444_3333_2222);
        wait_valid("mr_wait");
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_data", 64'(out_data), 64'd0);
        chk("mr_level", 64'(fifo_level), 64'd0);
        @(posedge clk_adc);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        push(8'h42, 56'h00_0000_0000_0042);
        chk("first_wr", 64'(fifo_level), 64'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/trig_record_reader.md
TRIG_RECORD_READER -- requirements
Module: trig_record_reader

Interface
REQ-001 The block SHALL have one clock, clk_adc, and one reset, reset; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk_adc, input, 1 bit: 125 MHz trigger-logic clock; all logic rising-edge.
- reset, input, 1 bit: asynchronous, active-high.
- clear, input, 1 bit: synchronous flush.
- rec_valid, input, 1 bit: one-cycle strobe committing a trigger record.
- rec_bits, input, 8 bits: fired-trigger bitmask for the record.
- rec_time, input, 56 bits: clock counter value at first trigger of the record.
- out_data, output, 32 bits: readout word.
- out_valid, output, 1 bit: out_data is valid.
- out_ready, input, 1 bit: consumer accepts the word.
- out_last, output, 1 bit: marks the final word of a record.
- fifo_level, output, 4 bits: records held, 0..8.
- overflow_count, output, 16 bits: count of dropped records.

Function
REQ-003 The block SHALL buffer records ({rec_bits, rec_time}) in an 8-deep FIFO, written on a clk_adc edge where rec_valid=1.
REQ-004 A record with rec_bits=0 SHALL be discarded and SHALL NOT count as an overflow.
REQ-005 The FSM SHALL have states IDLE, W0 and W1, plus W2 when TRIG_RECORD_SEQNUM_EN is defined.
REQ-006 In IDLE with fifo_level>0, the FSM SHALL move to W0 and present the head record.
REQ-007 Word formats SHALL be: W0 out_data = {bits[7:0], time[55:32]}; W1 out_data = time[31:0].
REQ-008 A word transfers on an edge where out_valid=1 and out_ready=1; W0 SHALL then go to W1, and the last word SHALL go to IDLE.
REQ-009 out_data, out_valid and out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-010 out_last SHALL be 1 only on the final word of a record.
REQ-011 The head record SHALL be popped on transfer of its last word.
REQ-012 Back-to-back records SHALL be handled so that after the last-word transfer, if the FIFO is non-empty, W0 of the next record is valid on the next edge (one idle cycle permitted via IDLE).
REQ-013 Latency: with an empty FIFO and the FSM in IDLE, a record sampled at edge N SHALL give out_valid=1 with W0 after edge N+2.
REQ-014 When full (fifo_level=8), a write SHALL be accepted if a pop occurs on the same edge; otherwise the record SHALL be dropped and overflow_count incremented, saturating at 65535.
REQ-015 Simultaneous write and pop SHALL leave fifo_level unchanged.
REQ-016 fifo_level SHALL include the record currently being transmitted.
REQ-017 Read and write pointers SHALL be 3 bits, wrapping 7->0.
REQ-018 clear=1 SHALL, on the next edge, empty the FIFO, return the FSM to IDLE, drop out_valid and out_last to 0, and zero overflow_count.
REQ-019 clear SHALL take priority over rec_valid and over out_ready on the same edge.

Reset
REQ-020 While reset=1, the block SHALL hold out_data=0, out_valid=0, out_last=0, fifo_level=0, overflow_count=0, pointers=0, FSM=IDLE and sequence counter=0.
REQ-021 Assertion of reset mid-record SHALL abandon the record without completing it.
REQ-022 FIFO storage contents need not be reset.
REQ-023 The first write SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-024 Macro TRIG_RECORD_SEQNUM_EN defined: each record SHALL be 3 words, with W2 out_data = {8'hA5, 8'h00, seq[15:0]} and out_last on W2.
REQ-025 seq SHALL be a 16-bit counter of transmitted records that increments on W2 transfer, wraps 65535->0, and is cleared by reset and clear.
REQ-026 Macro TRIG_RECORD_SEQNUM_EN undefined: records SHALL be 2 words with out_last on W1, and no W2 state or seq logic SHALL exist.

Verification
REQ-027 Single record, out_ready=1: rec_bits=8'h05, rec_time=56'h00_1234_5678_9ABC at edge 0 -> out_data=32'h0500_1234 valid after edge 2, then 32'h5678_9ABC with out_last=1, then out_valid=0 and fifo_level=0.
REQ-028 Backpressure: out_ready=0 for 10 cycles during W0 -> out_data and out_valid are stable for all 10 cycles, and exactly 2 transfers occur after release.
REQ-029 Overflow: 10 records with out_ready=0 -> fifo_level=8 and overflow_count=2; after draining, records 1..8 emerge in order.
REQ-030 Full plus pop: fifo_level=8 with a W1 transfer on the same edge as rec_valid -> fifo_level stays 8 and overflow_count is unchanged.
REQ-031 Zero mask and clear: rec_bits=0 -> no output, level 0. Then clear asserted while in W1 with 3 records queued -> next cycle out_valid=0, fifo_level=0, overflow_count=0.
REQ-032 With TRIG_RECORD_SEQNUM_EN defined: 3 records -> third words are 32'hA500_0000, 32'hA500_0001 and 32'hA500_0002, each with out_last=1.
